// File: rtl/auth_pkg.sv
// -----------------------------------------------------------------------------
// auth_pkg
// Shared definitions for the USB Type-C authentication certificate path:
//   - sched_state_e : read-scheduler FSM states
//   - certificate size constants (bytes)
//   - default streaming chunk size
// No ports (package).
// -----------------------------------------------------------------------------
package auth_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_XFER  = 2'd3
    } sched_state_e;

    localparam int MaxLeafCertSize         = 640;
    localparam int MaxIntermediateCertSize = 512;
    localparam int MaxACDSize              = 128;
    localparam int MaxCertChainSize        = 4096;

    localparam int CHUNK_MAX_DEFAULT       = 64;

endpackage

// File: rtl/auth_cert_read_sched_if.sv
// -----------------------------------------------------------------------------
// auth_cert_read_sched_if
// Bundles the request, memory-read, byte-stream and response signals of the
// certificate-chain read scheduler.
//   slave  : scheduler side (accepts requests, drives memory reads and output)
//   master : environment side (requesters, chain memory, byte consumer)
// Optional: AUTH_CERT_SCHED_ABORT_EN adds the per-requester abort strobe.
// -----------------------------------------------------------------------------
interface auth_cert_read_sched_if #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 13
);
    logic [1:0]          req_valid;
    logic [2*ADDR_W-1:0] req_offset;
    logic [2*LEN_W-1:0]  req_length;
    logic [1:0]          req_ready;
    logic [LEN_W-1:0]    chain_len;

    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_rd_data;
    logic                mem_rd_valid;

    logic                out_valid;
    logic                out_ready;
    logic [7:0]          out_data;
    logic                out_owner;
    logic                out_last;

    logic [1:0]          resp_done;
    logic [1:0]          resp_err;
`ifdef AUTH_CERT_SCHED_ABORT_EN
    logic [1:0]          abort;
`endif

    modport slave (
`ifdef AUTH_CERT_SCHED_ABORT_EN
        input  abort,
`endif
        input  req_valid, req_offset, req_length, chain_len,
        input  mem_rd_data, mem_rd_valid, out_ready,
        output req_ready, mem_rd_en, mem_addr,
        output out_valid, out_data, out_owner, out_last,
        output resp_done, resp_err
    );

    modport master (
`ifdef AUTH_CERT_SCHED_ABORT_EN
        output abort,
`endif
        output req_valid, req_offset, req_length, chain_len,
        output mem_rd_data, mem_rd_valid, out_ready,
        input  req_ready, mem_rd_en, mem_addr,
        input  out_valid, out_data, out_owner, out_last,
        input  resp_done, resp_err
    );

endinterface

// File: rtl/auth_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// auth_rr_arbiter2
// Two-way round-robin arbiter. On a tie the requester that did not win last
// time is granted.
//   active_i[1:0]  : requesters wanting service
//   last_owner_i   : id of the previous grant
//   grant_o[1:0]   : one-hot grant (zero when nothing is active)
//   grant_id_o     : id of the granted requester
// -----------------------------------------------------------------------------
module auth_rr_arbiter2 (
    input  logic [1:0] active_i,
    input  logic       last_owner_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

    always_comb begin
        grant_id_o = 1'b0;
        case (active_i)
            2'b01:   grant_id_o = 1'b0;
            2'b10:   grant_id_o = 1'b1;
            2'b11:   grant_id_o = ~last_owner_i;
            default: grant_id_o = 1'b0;
        endcase
        grant_o = 2'b00;
        if (|active_i) begin
            grant_o[grant_id_o] = 1'b1;
        end
    end

endmodule

// File: rtl/auth_cert_read_sched.sv
// -----------------------------------------------------------------------------
// auth_cert_read_sched
// Certificate-chain read scheduler. Shares the single chain memory between the
// CC1 (requester 0) and CC2 (requester 1) paths. Each request (offset, length)
// is bounds-checked against chain_len, then streamed byte by byte in chunks of
// at most CHUNK_MAX, round-robining between active requesters per chunk.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high
//   bus    : auth_cert_read_sched_if.slave (requests, memory reads, byte
//            stream, completion responses)
// Optional: `define AUTH_CERT_SCHED_ABORT_EN adds bus.abort[1:0].
// -----------------------------------------------------------------------------
module auth_cert_read_sched
    import auth_pkg::*;
#(
    parameter int CHAIN_SIZE_MAX = MaxCertChainSize,
    parameter int CHUNK_MAX      = CHUNK_MAX_DEFAULT,
    parameter int ADDR_W         = 12,
    parameter int LEN_W          = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    auth_cert_read_sched_if.slave  bus
);

    localparam int CW = $clog2(CHUNK_MAX + 1);

    sched_state_e      state_q, state_d;
    logic [1:0]        act_q, act_d;
    logic [ADDR_W-1:0] addr_q [2];
    logic [ADDR_W-1:0] addr_d [2];
    logic [LEN_W-1:0]  rem_q  [2];
    logic [LEN_W-1:0]  rem_d  [2];
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [CW-1:0]     chunk_q, chunk_d;
    logic [7:0]        data_q, data_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;

    logic [ADDR_W-1:0] req_off [2];
    logic [LEN_W-1:0]  req_len [2];
    logic [1:0]        acc_ok, acc_rej;
    logic [LEN_W-1:0]  chain_lim;
    logic [1:0]        abort_now;
    logic              owner_abort;
    logic [1:0]        grant;
    logic              grant_id;

    // chain_len can never legitimately exceed the physical chain memory
    assign chain_lim = (bus.chain_len > LEN_W'(CHAIN_SIZE_MAX)) ? LEN_W'(CHAIN_SIZE_MAX)
                                                                 : bus.chain_len;

    for (genvar g = 0; g < 2; g++) begin : g_req
        logic [LEN_W:0] end_sum;
        logic           fire;
        assign req_off[g]  = bus.req_offset[g*ADDR_W +: ADDR_W];
        assign req_len[g]  = bus.req_length[g*LEN_W +: LEN_W];
        // one extra bit so offset+length cannot wrap past the limit
        assign end_sum     = (LEN_W+1)'(req_off[g]) + (LEN_W+1)'(req_len[g]);
        assign fire        = bus.req_valid[g] & ~act_q[g];
        assign acc_ok[g]   = fire & (req_len[g] != '0) & (end_sum <= {1'b0, chain_lim});
        assign acc_rej[g]  = fire & ~acc_ok[g];
    end

`ifdef AUTH_CERT_SCHED_ABORT_EN
    logic abort_pend_q, abort_pend_d;
    logic wait_abort;

    // The owner waiting on memory cannot drop its read; it is handled in WAIT.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            abort_now[i] = bus.abort[i] & act_q[i] &
                           ~((state_q == ST_WAIT) && (owner_q == 1'(i)));
        end
    end
    assign owner_abort = abort_now[owner_q] & ((state_q == ST_ISSUE) | (state_q == ST_XFER));
    assign wait_abort  = abort_pend_q | (bus.abort[owner_q] & act_q[owner_q]);
`else
    assign abort_now   = 2'b00;
    assign owner_abort = 1'b0;
`endif

    auth_rr_arbiter2 u_arb (
        .active_i     (act_q & ~abort_now),
        .last_owner_i (last_owner_q),
        .grant_o      (grant),
        .grant_id_o   (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        act_d        = act_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        chunk_d      = chunk_q;
        data_d       = data_q;
        done_d       = 2'b00;
        err_d        = 2'b00;
`ifdef AUTH_CERT_SCHED_ABORT_EN
        abort_pend_d = abort_pend_q;
`endif

        for (int i = 0; i < 2; i++) begin
            if (abort_now[i]) begin
                act_d[i]  = 1'b0;
                done_d[i] = 1'b1;
                err_d[i]  = 1'b1;
            end
            if (acc_ok[i]) begin
                act_d[i]  = 1'b1;
                addr_d[i] = req_off[i];
                rem_d[i]  = req_len[i];
            end else if (acc_rej[i]) begin
                done_d[i] = 1'b1;
                err_d[i]  = 1'b1;
            end
        end

        case (state_q)
            ST_ARB: begin
                if (|grant) begin
                    owner_d      = grant_id;
                    last_owner_d = grant_id;
                    chunk_d      = '0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = owner_abort ? ST_ARB : ST_WAIT;
            end
            ST_WAIT: begin
`ifdef AUTH_CERT_SCHED_ABORT_EN
                if (bus.mem_rd_valid && wait_abort) begin
                    // the in-flight byte is swallowed before the context is released
                    act_d[owner_q]  = 1'b0;
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = 1'b1;
                    abort_pend_d    = 1'b0;
                    state_d         = ST_ARB;
                end else if (bus.mem_rd_valid) begin
                    data_d  = bus.mem_rd_data;
                    state_d = ST_XFER;
                end else if (wait_abort) begin
                    abort_pend_d = 1'b1;
                end
`else
                if (bus.mem_rd_valid) begin
                    data_d  = bus.mem_rd_data;
                    state_d = ST_XFER;
                end
`endif
            end
            ST_XFER: begin
                if (owner_abort) begin
                    state_d = ST_ARB;
                end else if (bus.out_ready) begin
                    addr_d[owner_q] = addr_q[owner_q] + ADDR_W'(1);
                    rem_d[owner_q]  = rem_q[owner_q] - LEN_W'(1);
                    chunk_d         = chunk_q + CW'(1);
                    if (rem_q[owner_q] == LEN_W'(1)) begin
                        act_d[owner_q]  = 1'b0;
                        done_d[owner_q] = 1'b1;
                        state_d         = ST_ARB;
                    end else if (chunk_q + CW'(1) == CW'(CHUNK_MAX)) begin
                        state_d = ST_ARB;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_ARB;
            act_q        <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                addr_q[i] <= '0;
                rem_q[i]  <= '0;
            end
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            chunk_q      <= '0;
            data_q       <= '0;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            act_q        <= act_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            chunk_q      <= chunk_d;
            data_q       <= data_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

`ifdef AUTH_CERT_SCHED_ABORT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abort_pend_q <= 1'b0;
        end else begin
            abort_pend_q <= abort_pend_d;
        end
    end
`endif

    assign bus.req_ready = ~act_q;
    assign bus.mem_rd_en = (state_q == ST_ISSUE);
    assign bus.mem_addr  = (state_q == ST_ISSUE) ? addr_q[owner_q] : '0;
    assign bus.out_valid = (state_q == ST_XFER) & ~owner_abort;
    assign bus.out_data  = data_q;
    assign bus.out_owner = owner_q;
    assign bus.out_last  = (state_q == ST_XFER) & ~owner_abort & (rem_q[owner_q] == LEN_W'(1));
    assign bus.resp_done = done_q;
    assign bus.resp_err  = err_q;

endmodule

// File: tb/tb_auth_cert_read_sched.sv
`timescale 1ns/1ps
module tb_auth_cert_read_sched;

    localparam int ADDR_W = 12;
    localparam int LEN_W  = 13;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    auth_cert_read_sched_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    auth_cert_read_sched #(
        .CHAIN_SIZE_MAX (4096),
        .CHUNK_MAX      (64),
        .ADDR_W         (ADDR_W),
        .LEN_W          (LEN_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [11:0] a);
        return a[7:0] ^ {4'h0, a[11:8]} ^ 8'h5A;
    endfunction

    // scoreboard queues
    exp_t exp0[$];
    exp_t exp1[$];
    bit   rsp0[$];
    bit   rsp1[$];
    int   own_log[$];
    int   addr_log[$];
    int   hs_cnt = 0;
    int   resp_cnt = 0;
    int   rd_cnt = 0;
    int   lat = 1;

    // chain memory model: fixed latency, one outstanding read
    initial begin
        logic [11:0] a;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_rd_en && !reset) begin
                a = bus.mem_addr;
                rd_cnt++;
                addr_log.push_back(int'(a));
                repeat (lat) @(posedge clk);
                #2;
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data  = mem_byte(a);
                @(posedge clk);
                #2;
                bus.mem_rd_valid = 1'b0;
                bus.mem_rd_data  = 8'h00;
            end
        end
    end

    // output / response monitor
    bit         stall_pend = 0;
    logic [7:0] st_data;
    logic       st_owner, st_last;

    always @(negedge clk) begin
        exp_t e;
        bit   r;
        if (reset) begin
            stall_pend = 0;
        end else begin
            if (stall_pend) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_data",  32'(bus.out_data),  32'(st_data));
                check("stall_owner", 32'(bus.out_owner), 32'(st_owner));
                check("stall_last",  32'(bus.out_last),  32'(st_last));
            end
            stall_pend = 0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    hs_cnt++;
                    own_log.push_back(int'(bus.out_owner));
                    if ((bus.out_owner == 1'b0 && exp0.size() == 0) ||
                        (bus.out_owner == 1'b1 && exp1.size() == 0)) begin
                        check("unexpected_byte", 32'(bus.out_owner), 32'd2);
                    end else begin
                        e = (bus.out_owner == 1'b0) ? exp0.pop_front() : exp1.pop_front();
                        check("byte_data", 32'(bus.out_data), 32'(e.d));
                        check("byte_last", 32'(bus.out_last), 32'(e.last));
                    end
                end else begin
                    stall_pend = 1;
                    st_data  = bus.out_data;
                    st_owner = bus.out_owner;
                    st_last  = bus.out_last;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (bus.resp_done[i]) begin
                    resp_cnt++;
                    if ((i == 0 && rsp0.size() == 0) || (i == 1 && rsp1.size() == 0)) begin
                        check("unexpected_resp", 32'(i), 32'd2);
                    end else begin
                        r = (i == 0) ? rsp0.pop_front() : rsp1.pop_front();
                        check("resp_err", 32'(bus.resp_err[i]), 32'(r));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input int i, input int off, input int len, input bit ok);
        exp_t e;
        logic [11:0] a;
        if (ok) begin
            for (int k = 0; k < len; k++) begin
                a = 12'(off + k);
                e.d = mem_byte(a);
                e.last = (k == len - 1);
                if (i == 0) exp0.push_back(e); else exp1.push_back(e);
            end
        end
        if (i == 0) rsp0.push_back(!ok); else rsp1.push_back(!ok);
    endtask

    task automatic set_req(input int i, input int off, input int len);
        logic [31:0] o;
        logic [31:0] l;
        o = 32'(off);
        l = 32'(len);
        bus.req_offset[i*ADDR_W +: ADDR_W] = o[ADDR_W-1:0];
        bus.req_length[i*LEN_W +: LEN_W]   = l[LEN_W-1:0];
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic send_req(input int i, input int off, input int len, input bit ok);
        int guard = 0;
        while (!bus.req_ready[i] && guard < 3000) begin
            tick();
            guard++;
        end
        if (!bus.req_ready[i]) check("req_ready_timeout", 32'd0, 32'd1);
        push_exp(i, off, len, ok);
        set_req(i, off, len);
        tick();
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int guard = 0;
        while ((exp0.size() + exp1.size() + rsp0.size() + rsp1.size() != 0) && guard < 5000) begin
            tick();
            guard++;
        end
        check(tag, 32'(exp0.size() + exp1.size() + rsp0.size() + rsp1.size()), 32'd0);
        tick();
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, hs0, rs0, guard;
        int ch_own[$];
        int ch_len[$];
        int exp_own[6];
        int exp_len[6];
        exp_own = '{0, 1, 0, 1, 0, 1};
        exp_len = '{64, 64, 64, 64, 2, 2};

        bus.req_valid  = 2'b00;
        bus.req_offset = '0;
        bus.req_length = '0;
        bus.chain_len  = 13'd640;
        bus.out_ready  = 1'b1;
`ifdef AUTH_CERT_SCHED_ABORT_EN
        bus.abort = 2'b00;
`endif
        reset = 1'b1;
        repeat (3) tick();
        check("rst_req_ready", 32'(bus.req_ready), 32'd3);
        check("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_out_owner", 32'(bus.out_owner), 32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_resp_done", 32'(bus.resp_done), 32'd0);
        check("rst_resp_err",  32'(bus.resp_err),  32'd0);
        reset = 1'b0;
        tick();

        // single request, latency 1
        lat = 1;
        addr_log.delete();
        send_req(0, 'h010, 5, 1);
        check("acc_req_ready", 32'(bus.req_ready), 32'd2);
        wait_idle("t1_drain");
        check("t1_rd_count", 32'(addr_log.size()), 32'd5);
        for (int k = 0; k < 5 && k < addr_log.size(); k++)
            check("t1_addr", 32'(addr_log[k]), 32'('h010 + k));

        // rejections
        rd0 = rd_cnt;
        send_req(1, 600, 41, 0);
        check("rej_range_done", 32'(bus.resp_done), 32'd2);
        check("rej_range_err",  32'(bus.resp_err),  32'd2);
        check("rej_range_ready", 32'(bus.req_ready), 32'd3);
        tick();
        send_req(1, 100, 0, 0);
        check("rej_zero_done", 32'(bus.resp_done), 32'd2);
        check("rej_zero_err",  32'(bus.resp_err),  32'd2);
        repeat (4) tick();
        check("rej_no_read", 32'(rd_cnt - rd0), 32'd0);
        wait_idle("rej_drain");
        send_req(1, 600, 40, 1);
        check("edge_acc_ready", 32'(bus.req_ready), 32'd1);
        wait_idle("edge_drain");

        // both active, 130 bytes each
        own_log.delete();
        push_exp(0, 0, 130, 1);
        push_exp(1, 200, 130, 1);
        set_req(0, 0, 130);
        set_req(1, 200, 130);
        tick();
        bus.req_valid = 2'b00;
        wait_idle("rr_drain");
        foreach (own_log[k]) begin
            if (k == 0 || own_log[k] != own_log[k-1]) begin
                ch_own.push_back(own_log[k]);
                ch_len.push_back(1);
            end else begin
                ch_len[ch_len.size()-1]++;
            end
        end
        check("rr_chunks", 32'(ch_own.size()), 32'd6);
        for (int k = 0; k < 6 && k < ch_own.size(); k++) begin
            check("rr_owner", 32'(ch_own[k]), 32'(exp_own[k]));
            check("rr_len",   32'(ch_len[k]), 32'(exp_len[k]));
        end

        // consumer stall, latency 4
        lat = 4;
        hs0 = hs_cnt;
        send_req(0, 'h020, 6, 1);
        guard = 0;
        while (!bus.out_valid && guard < 200) begin
            tick();
            guard++;
        end
        check("stall_seen_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b0;
        repeat (10) tick();
        bus.out_ready = 1'b1;
        wait_idle("stall_drain");
        check("stall_count", 32'(hs_cnt - hs0), 32'd6);

        // reset while waiting on memory
        lat = 2;
        send_req(0, 0, 3, 1);
        guard = 0;
        while (!bus.mem_rd_en && guard < 200) begin
            tick();
            guard++;
        end
        check("rstw_issue", 32'(bus.mem_rd_en), 32'd1);
        tick();
        reset = 1'b1;
        exp0.delete(); exp1.delete(); rsp0.delete(); rsp1.delete();
        #1;
        check("rstw_ready", 32'(bus.req_ready), 32'd3);
        check("rstw_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        reset = 1'b0;
        hs0 = hs_cnt; rs0 = resp_cnt; rd0 = rd_cnt;
        repeat (10) tick();
        check("rstw_no_byte", 32'(hs_cnt - hs0), 32'd0);
        check("rstw_no_resp", 32'(resp_cnt - rs0), 32'd0);
        check("rstw_no_read", 32'(rd_cnt - rd0), 32'd0);
        check("rstw_ready2", 32'(bus.req_ready), 32'd3);

`ifdef AUTH_CERT_SCHED_ABORT_EN
        // abort requester 0 in WAIT; requester 1 must be served next
        lat = 3;
        rd0 = rd_cnt;
        push_exp(0, 0, 100, 0);
        set_req(0, 0, 100);
        tick();
        bus.req_valid = 2'b00;
        guard = 0;
        while (!bus.mem_rd_en && guard < 200) begin
            tick();
            guard++;
        end
        tick();
        addr_log.delete();
        bus.abort[0] = 1'b1;
        push_exp(1, 300, 3, 1);
        set_req(1, 300, 3);
        tick();
        bus.abort = 2'b00;
        bus.req_valid = 2'b00;
        wait_idle("abort_drain");
        check("abort_reads", 32'(rd_cnt - rd0), 32'd4);
        if (addr_log.size() > 0) check("abort_next_addr", 32'(addr_log[0]), 32'd300);
        else check("abort_next_addr", 32'd0, 32'd300);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/auth_cert_read_sched.md
# auth_cert_read_sched

Certificate-chain read scheduler for the USB Type-C authentication driver. It owns the single certificate-chain memory and shares it between two requesters: requester 0 is the CC1-orientation path and requester 1 is the CC2-orientation path. Each request is a byte range (offset, length). The block bounds-checks the range, then streams the bytes out in chunks of at most CHUNK_MAX, round-robining between active requesters at chunk boundaries.

## Interface
- CHAIN_SIZE_MAX, 4096: max certificate chain size, in bytes.
- CHUNK_MAX, 64: bytes streamed per grant before re-arbitration; range 1..CHAIN_SIZE_MAX.
- ADDR_W, 12: byte address width into chain memory.
- LEN_W, 13: length/offset-sum width; must hold CHAIN_SIZE_MAX.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- req_valid  in  2  per-requester request strobe.
- req_offset  in  2*ADDR_W  per-requester start byte; requester i at bits [i*ADDR_W +: ADDR_W].
- req_length  in  2*LEN_W  per-requester byte count; same packing.
- req_ready  out  2  context i idle; request accepted on req_valid[i] & req_ready[i].
- chain_len  in  LEN_W  valid bytes currently stored; quasi-static during transfers.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  read address, valid with mem_rd_en.
- mem_rd_data  in  8  read byte.
- mem_rd_valid  in  1  read data valid; latency ≥1 cycle, unbounded.
- out_valid  out  1  byte available.
- out_ready  in  1  consumer accepts the byte.
- out_data  out  8  byte.
- out_owner  out  1  requester the byte belongs to.
- out_last  out  1  final byte of the owner's request.
- resp_done  out  2  one-cycle completion pulse per requester.
- resp_err  out  2  valid with resp_done; 1 = request rejected.

## Operation
- Each requester has a context: active flag, cur_addr (ADDR_W), remaining (LEN_W).
- Acceptance check: reject if length==0 or offset+length > chain_len. The sum is computed in LEN_W+1 bits, so it never wraps.
- On rejection: resp_done[i]=resp_err[i]=1 for one cycle. The context stays idle and no memory access occurs.
- On success: the context loads and goes active. req_ready[i]=0 until resp_done[i].
- FSM states:
  - ARB: if no context is active, stay. If one is active, grant it. If both are active, grant !last_owner. Record last_owner and clear chunk_cnt → ISSUE.
  - ISSUE: mem_rd_en=1, mem_addr=cur_addr → WAIT.
  - WAIT: on mem_rd_valid, capture mem_rd_data → XFER.
  - XFER: out_valid=1 until out_ready. On handshake: cur_addr++, remaining--, chunk_cnt++.
    - If remaining hits 0: pulse resp_done[owner] (resp_err=0), deactivate the context → ARB.
    - Else if chunk_cnt==CHUNK_MAX → ARB.
    - Else → ISSUE.
- mem_rd_valid is ignored outside WAIT.
- The idle context may be accepted in any cycle, including while the other context is streaming.
- Reset mid-transfer:
  - Both contexts are cleared and the FSM goes to ARB.
  - Pending memory data is discarded.
  - No resp_done is issued for the aborted request.
- Reset values:
  - Outputs: req_ready=2'b11; all other outputs 0.
  - last_owner=1, so requester 0 wins the first tie.

## Timing
- Acceptance at edge T: context active and req_ready[i]=0 from T+1. A rejection pulse appears at T+1.
- ARB→ISSUE takes 1 cycle. mem_rd_en is high for exactly one cycle per byte.
- out_valid rises the cycle after mem_rd_valid is sampled. out_data, out_owner and out_last are stable while out_valid=1 and out_ready=0.
- Minimum 3 cycles per byte (ISSUE, WAIT with latency 1, XFER).
- The final handshake at edge T gives resp_done at T+1, and req_ready[i]=1 at T+1. A new request is accepted at the earliest at T+1.
- With both requesters active, chunks alternate strictly: 0,1,0,1...

## Configuration
- AUTH_CERT_SCHED_ABORT_EN defined: adds input abort (2 bits).
  - abort[i] on an idle context is ignored.
  - On the active context (inactive-owner or owner in ARB/ISSUE/XFER): it clears the context next cycle and pulses resp_done[i]=resp_err[i]=1. An XFER byte is dropped without out_valid handshake.
  - Owner in WAIT: the FSM waits for mem_rd_valid, discards the byte, then issues the same pulse → ARB.
- Undefined: no abort port; requests always run to completion or reset.

## Structure
- Shared package auth_pkg holds:
  - The FSM state enum.
  - The certificate size constants: MaxLeafCertSize 640, MaxIntermediateCertSize 512, MaxACDSize 128, MaxCertChainSize 4096.
  - Default CHUNK_MAX.
- Sub-module auth_rr_arbiter2: a 2-way round-robin arbiter (active[1:0], last_owner → grant, grant_id).

## Test plan
- Single request, requester 0, offset 0x010, length 5, chain_len 640, memory latency 1 → 5 bytes from addresses 0x010..0x014. out_last is set on the 5th byte only, then resp_done[0]=1 with resp_err=0.
- Reject cases:
  - offset 600, length 41, chain_len 640 → resp_done[1]=resp_err[1]=1 at T+1, no mem_rd_en.
  - length 0 → same rejection response.
  - offset 600, length 40 → accepted.
- Both requesters active, length 130 each, CHUNK_MAX 64 → owner chunk sequence 0(64),1(64),0(64),1(64),0(2),1(2).
- out_ready held low 10 cycles mid-stream, memory latency 4 → no byte lost or duplicated; outputs stable while stalled.
- Reset asserted in WAIT with mem_rd_valid arriving next cycle → data ignored, req_ready=2'b11, no resp_done, no out_valid.
- Abort (macro on): abort[0] in WAIT → one further mem_rd_valid is absorbed, then resp_done[0]=resp_err[0]=1, and requester 1 is granted next.
